tuss_burst_gen: RTL and testbench

- Ultrasonic transducer burst driver downstream of the detection controller; consumes `burst_en`/`burst_rstn` and returns `burst_finish`.
- On request, drives the TUSS driver chip IO1/IO2 pins with PULSE_NUM cycles at the excitation frequency.
- Supports single-ended IO mode and complementary mode with dead time.
- Holds `burst_finish` until the controller acknowledges with `burst_rstn` low.

---
 rtl/tuss_pkg.sv | 46 ++++
 rtl/tuss_phase_gen.sv | 74 +++++++
 rtl/tuss_burst_gen.sv | 106 ++++++++++
 tb/tb_tuss_burst_gen.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tuss_pkg.sv
// Shared definitions for the TUSS ultrasonic burst driver: FSM state
// encoding, default 40 kHz timing constants, IO mode encodings and the
// IO1/IO2 waveform decode used by the phase generator.
package tuss_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DRIVE  = 2'd1,
        ST_FINISH = 2'd2
    } tuss_state_t;

    // 50 MHz system clock, 40 kHz excitation -> 625 clocks per half-period.
    localparam int HALF_CYCLES_40K = 625;
    localparam int PULSE_NUM_DEF   = 16;
    localparam int DEAD_CYCLES_DEF = 10;

    localparam logic IO_MODE_SE   = 1'b0;
    localparam logic IO_MODE_COMP = 1'b1;

    localparam int PH_W   = 13;
    localparam int PCNT_W = 8;

    // Returns {io1, io2} for a phase position within one excitation period.
    // Single-ended: IO1 is a steady enable and IO2 carries the square wave.
    // Complementary: each pin owns one half-period, and the first `dead`
    // clocks of every half-period keep both pins low so the driver's
    // bridge never conducts through both legs at once.
    function automatic logic [1:0] io_decode(
        input logic [PH_W-1:0] ph,
        input logic            mode,
        input logic [PH_W-1:0] half,
        input logic [PH_W-1:0] dead,
        input logic [PH_W-1:0] half_dead
    );
        logic [1:0] io;
        if (mode == IO_MODE_COMP) begin
            io[1] = (ph >= dead) && (ph < half);
            io[0] = (ph >= half_dead);
        end else begin
            io[1] = 1'b1;
            io[0] = (ph < half);
        end
        return io;
    endfunction

endpackage

// File: rtl/tuss_phase_gen.sv
// Excitation phase counter and IO1/IO2 waveform generator. The counter
// sweeps one full excitation period and wraps; pin levels are registered
// from the *next* phase value so they line up with the counter and the
// parent's state without an extra cycle of latency.
module tuss_phase_gen
    import tuss_pkg::*;
#(
    parameter int HALF_CYCLES = HALF_CYCLES_40K,
    parameter int DEAD_CYCLES = DEAD_CYCLES_DEF
) (
    input  logic gclk,
    input  logic rstn,
    input  logic start,        // entering DRIVE this cycle: restart phase, latch mode
    input  logic active,       // currently in DRIVE
    input  logic run,          // will be in DRIVE next cycle
    input  logic io_mode,
    output logic io1,
    output logic io2,
    output logic period_done   // last phase of the current period
);

    localparam logic [PH_W-1:0] PH_HALF      = PH_W'(HALF_CYCLES);
    localparam logic [PH_W-1:0] PH_DEAD      = PH_W'(DEAD_CYCLES);
    localparam logic [PH_W-1:0] PH_HALF_DEAD = PH_W'(HALF_CYCLES + DEAD_CYCLES);
    localparam logic [PH_W-1:0] PH_LAST      = PH_W'(2 * HALF_CYCLES - 1);

    logic [PH_W-1:0] ph;
    logic [PH_W-1:0] ph_next;
    logic            mode;
    logic            mode_eff;
    logic [1:0]      io_next;

    // The mode sampled on the start cycle applies to the very first phase.
    always_comb begin
        mode_eff = start ? io_mode : mode;
    end

    // Phase advance: restart on entry, count while driving, park at zero otherwise.
    always_comb begin
        ph_next = '0;
        if (run && !start) begin
            ph_next = (ph == PH_LAST) ? '0 : ph + 1'b1;
        end
    end

    // Pin levels for the upcoming cycle; both low whenever DRIVE is left.
    always_comb begin
        io_next = 2'b00;
        if (run) begin
            io_next = io_decode(ph_next, mode_eff, PH_HALF, PH_DEAD, PH_HALF_DEAD);
        end
    end

    // Period wrap strobe to the parent FSM.
    always_comb begin
        period_done = active && (ph == PH_LAST);
    end

    // Phase, latched mode and pin registers.
    always_ff @(posedge gclk or negedge rstn) begin
        if (!rstn) begin
            ph   <= '0;
            mode <= 1'b0;
            io1  <= 1'b0;
            io2  <= 1'b0;
        end else begin
            ph   <= ph_next;
            mode <= mode_eff;
            io1  <= io_next[1];
            io2  <= io_next[0];
        end
    end

endmodule

// File: rtl/tuss_burst_gen.sv
// TUSS transducer burst driver. A level request in IDLE launches a burst
// of PULSE_NUM excitation periods on IO1/IO2; completion is flagged on
// burst_finish and held until the controller clears it with burst_rstn
// low. burst_rstn low during a burst aborts it without flagging finish.
module tuss_burst_gen
    import tuss_pkg::*;
#(
    parameter int HALF_CYCLES = HALF_CYCLES_40K,
    parameter int PULSE_NUM   = PULSE_NUM_DEF,
    parameter int DEAD_CYCLES = DEAD_CYCLES_DEF
) (
    input  logic       gclk,
    input  logic       rstn,
    input  logic       burst_en,
    input  logic       burst_rstn,
    input  logic       io_mode,
    output logic       io1,
    output logic       io2,
    output logic       burst_finish,
    output logic       busy,
    output logic [7:0] pulse_cnt
);

    localparam logic [PCNT_W-1:0] PCNT_LAST = PCNT_W'(PULSE_NUM - 1);

    tuss_state_t       state;
    tuss_state_t       state_next;
    logic              period_done;
    logic              start;
    logic              active;
    logic              run;
    logic              busy_next;
    logic              finish_next;
    logic [PCNT_W-1:0] pulse_cnt_next;

    tuss_phase_gen #(
        .HALF_CYCLES (HALF_CYCLES),
        .DEAD_CYCLES (DEAD_CYCLES)
    ) u_phase_gen (
        .gclk        (gclk),
        .rstn        (rstn),
        .start       (start),
        .active      (active),
        .run         (run),
        .io_mode     (io_mode),
        .io1         (io1),
        .io2         (io2),
        .period_done (period_done)
    );

    // State register plus the registered status outputs.
    always_ff @(posedge gclk or negedge rstn) begin
        if (!rstn) begin
            state        <= ST_IDLE;
            busy         <= 1'b0;
            burst_finish <= 1'b0;
            pulse_cnt    <= '0;
        end else begin
            state        <= state_next;
            busy         <= busy_next;
            burst_finish <= finish_next;
            pulse_cnt    <= pulse_cnt_next;
        end
    end

    // Next-state logic; a low burst_rstn always wins over a request.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (burst_en && burst_rstn) begin
                    state_next = ST_DRIVE;
                end
            end
            ST_DRIVE: begin
                if (!burst_rstn) begin
                    state_next = ST_IDLE;
                end else if (period_done && (pulse_cnt == PCNT_LAST)) begin
                    state_next = ST_FINISH;
                end
            end
            ST_FINISH: begin
                if (!burst_rstn) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Output/next-value logic for the status registers and phase generator controls.
    always_comb begin
        active         = (state == ST_DRIVE);
        run            = (state_next == ST_DRIVE);
        start          = (state == ST_IDLE) && (state_next == ST_DRIVE);
        busy_next      = (state_next != ST_IDLE);
        finish_next    = (state_next == ST_FINISH);
        pulse_cnt_next = pulse_cnt;
        if (state_next == ST_IDLE || start) begin
            pulse_cnt_next = '0;
        end else if (active && period_done) begin
            pulse_cnt_next = pulse_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_tuss_burst_gen.sv
// Directed bench for tuss_burst_gen: a small instance (4/3/1) exercises
// waveforms, handshake, abort and async reset; a default-parameter
// instance checks the full 40 kHz burst length and duty.
module tb_tuss_burst_gen;

    logic       gclk;
    logic       rstn;
    logic       burst_en;
    logic       burst_rstn;
    logic       io_mode;
    logic       io1;
    logic       io2;
    logic       burst_finish;
    logic       busy;
    logic [7:0] pulse_cnt;

    logic       d_en;
    logic       d_rstn_b;
    logic       d_mode;
    logic       d_io1;
    logic       d_io2;
    logic       d_finish;
    logic       d_busy;
    logic [7:0] d_pcnt;

    int total = 0;
    int bad   = 0;

    // Per-phase expected pin patterns for HALF=4, DEAD=1 (bit index = ph).
    logic [7:0] m0_io2 = 8'b0000_1111;
    logic [7:0] m1_io1 = 8'b0000_1110;
    logic [7:0] m1_io2 = 8'b1110_0000;

    tuss_burst_gen #(
        .HALF_CYCLES (4),
        .PULSE_NUM   (3),
        .DEAD_CYCLES (1)
    ) dut (
        .gclk         (gclk),
        .rstn         (rstn),
        .burst_en     (burst_en),
        .burst_rstn   (burst_rstn),
        .io_mode      (io_mode),
        .io1          (io1),
        .io2          (io2),
        .burst_finish (burst_finish),
        .busy         (busy),
        .pulse_cnt    (pulse_cnt)
    );

    tuss_burst_gen dut_def (
        .gclk         (gclk),
        .rstn         (rstn),
        .burst_en     (d_en),
        .burst_rstn   (d_rstn_b),
        .io_mode      (d_mode),
        .io1          (d_io1),
        .io2          (d_io2),
        .burst_finish (d_finish),
        .busy         (d_busy),
        .pulse_cnt    (d_pcnt)
    );

    initial gclk = 1'b0;
    always #5 gclk = ~gclk;

    // {io1, io2, busy, burst_finish, pulse_cnt}
    function automatic logic [11:0] obs();
        return {io1, io2, busy, burst_finish, pulse_cnt};
    endfunction

    task automatic test_reset();
        logic [11:0] o;
        rstn = 1'b0; burst_en = 1'b0; burst_rstn = 1'b1; io_mode = 1'b0;
        d_en = 1'b0; d_rstn_b = 1'b1; d_mode = 1'b0;
        repeat (3) @(negedge gclk);
        o = obs();
        total++;
        if (o !== 12'h000) begin
            bad++;
            $display("FAIL reset_held: got %h want %h", o, 12'h000);
        end
        rstn = 1'b1;
        repeat (2) @(negedge gclk);
        o = obs();
        total++;
        if (o !== 12'h000) begin
            bad++;
            $display("FAIL reset_released_idle: got %h want %h", o, 12'h000);
        end
        total++;
        if ({d_io1, d_io2, d_busy, d_finish, d_pcnt} !== 12'h000) begin
            bad++;
            $display("FAIL reset_default_inst: got %h want %h",
                     {d_io1, d_io2, d_busy, d_finish, d_pcnt}, 12'h000);
        end
        $display("test_reset done");
    endtask

    // One-cycle request then 24 DRIVE cycles checked against the phase tables;
    // io_mode is flipped right after the request to show it is latched.
    task automatic run_burst(input logic mode, input string tag);
        logic [11:0] o;
        logic [11:0] e;
        int ph;
        io_mode = mode; burst_en = 1'b1;
        @(negedge gclk);
        burst_en = 1'b0; io_mode = ~mode;
        for (int k = 0; k < 24; k++) begin
            ph = k % 8;
            e = {(mode ? m1_io1[ph] : 1'b1), (mode ? m1_io2[ph] : m0_io2[ph]),
                 1'b1, 1'b0, 8'(k / 8)};
            o = obs();
            total++;
            if (o !== e) begin
                bad++;
                $display("FAIL %s_drive_k%0d: got %h want %h", tag, k, o, e);
            end
            @(negedge gclk);
        end
        o = obs();
        total++;
        if (o !== 12'h303) begin
            bad++;
            $display("FAIL %s_finish: got %h want %h", tag, o, 12'h303);
        end
        $display("burst %s done", tag);
    endtask

    task automatic ack();
        logic [11:0] o;
        burst_rstn = 1'b0;
        @(negedge gclk);
        burst_rstn = 1'b1;
        o = obs();
        total++;
        if (o !== 12'h000) begin
            bad++;
            $display("FAIL ack_idle: got %h want %h", o, 12'h000);
        end
    endtask

    task automatic test_mode0();
        run_burst(1'b0, "mode0");
        ack();
    endtask

    task automatic test_mode1();
        run_burst(1'b1, "mode1");
    endtask

    task automatic test_ack_handshake();
        logic [11:0] o;
        burst_en = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge gclk);
            o = obs();
            total++;
            if (o !== 12'h303) begin
                bad++;
                $display("FAIL hold_finish_c%0d: got %h want %h", k, o, 12'h303);
            end
        end
        // Clear while the request is still up: FINISH -> IDLE, and the
        // following IDLE cycle with clear still low must not start.
        burst_rstn = 1'b0;
        @(negedge gclk);
        o = obs();
        total++;
        if (o !== 12'h000) begin
            bad++;
            $display("FAIL ack_clear: got %h want %h", o, 12'h000);
        end
        @(negedge gclk);
        o = obs();
        total++;
        if (o !== 12'h000) begin
            bad++;
            $display("FAIL idle_clear_wins: got %h want %h", o, 12'h000);
        end
        burst_en = 1'b0; burst_rstn = 1'b1;
        @(negedge gclk);
        run_burst(1'b0, "rearm");
        ack();
        $display("test_ack_handshake done");
    endtask

    task automatic test_abort();
        logic [11:0] o;
        logic fin_seen;
        io_mode = 1'b0; burst_en = 1'b1;
        @(negedge gclk);
        burst_en = 1'b0;
        repeat (9) @(negedge gclk);
        // DRIVE cycle 9: ph=1 of the second period.
        o = obs();
        total++;
        if (o !== 12'hE01) begin
            bad++;
            $display("FAIL abort_pre: got %h want %h", o, 12'hE01);
        end
        burst_rstn = 1'b0;
        @(negedge gclk);
        burst_rstn = 1'b1;
        o = obs();
        total++;
        if (o !== 12'h000) begin
            bad++;
            $display("FAIL abort_next: got %h want %h", o, 12'h000);
        end
        fin_seen = 1'b0;
        for (int k = 0; k < 30; k++) begin
            @(negedge gclk);
            if (burst_finish || busy || io1 || io2) fin_seen = 1'b1;
        end
        total++;
        if (fin_seen !== 1'b0) begin
            bad++;
            $display("FAIL abort_quiet: got %b want %b", fin_seen, 1'b0);
        end
        $display("test_abort done");
    endtask

    task automatic test_async_reset();
        logic [11:0] o;
        io_mode = 1'b1; burst_en = 1'b1;
        @(negedge gclk);
        burst_en = 1'b0;
        repeat (5) @(negedge gclk);
        // ph=5: io2 high in complementary mode before the reset hits.
        o = obs();
        total++;
        if (o !== 12'h600) begin
            bad++;
            $display("FAIL async_pre: got %h want %h", o, 12'h600);
        end
        #2 rstn = 1'b0;
        #1;
        o = obs();
        total++;
        if (o !== 12'h000) begin
            bad++;
            $display("FAIL async_immediate: got %h want %h", o, 12'h000);
        end
        @(negedge gclk);
        rstn = 1'b1;
        repeat (5) @(negedge gclk);
        o = obs();
        total++;
        if (o !== 12'h000) begin
            bad++;
            $display("FAIL async_stays_idle: got %h want %h", o, 12'h000);
        end
        run_burst(1'b1, "post_reset");
        ack();
        $display("test_async_reset done");
    endtask

    task automatic test_defaults();
        int drive_cnt;
        int io1_cnt;
        int io2_cnt;
        logic overlap;
        d_mode = 1'b1; d_en = 1'b1;
        @(negedge gclk);
        d_en = 1'b0; d_mode = 1'b0;
        drive_cnt = 0; io1_cnt = 0; io2_cnt = 0; overlap = 1'b0;
        while (d_busy && !d_finish && drive_cnt < 25000) begin
            if (drive_cnt < 1250) begin
                if (d_io1) io1_cnt++;
                if (d_io2) io2_cnt++;
            end
            if (d_io1 && d_io2) overlap = 1'b1;
            drive_cnt++;
            @(negedge gclk);
        end
        total++;
        if (drive_cnt !== 20000) begin
            bad++;
            $display("FAIL def_duration: got %0d want %0d", drive_cnt, 20000);
        end
        total++;
        if (io1_cnt !== 615) begin
            bad++;
            $display("FAIL def_io1_high: got %0d want %0d", io1_cnt, 615);
        end
        total++;
        if (io2_cnt !== 615) begin
            bad++;
            $display("FAIL def_io2_high: got %0d want %0d", io2_cnt, 615);
        end
        total++;
        if (overlap !== 1'b0) begin
            bad++;
            $display("FAIL def_overlap: got %b want %b", overlap, 1'b0);
        end
        total++;
        if ({d_io1, d_io2, d_busy, d_finish, d_pcnt} !== 12'h310) begin
            bad++;
            $display("FAIL def_finish: got %h want %h",
                     {d_io1, d_io2, d_busy, d_finish, d_pcnt}, 12'h310);
        end
        d_rstn_b = 1'b0;
        @(negedge gclk);
        d_rstn_b = 1'b1;
        total++;
        if ({d_busy, d_finish, d_pcnt} !== 10'h000) begin
            bad++;
            $display("FAIL def_ack: got %h want %h", {d_busy, d_finish, d_pcnt}, 10'h000);
        end
        $display("test_defaults done");
    endtask

    initial begin
        test_reset();
        test_mode0();
        test_mode1();
        test_ack_handshake();
        test_abort();
        test_async_reset();
        test_defaults();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
